// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
//   Shared definitions for the data-memory responder: FSM state encoding,
//   RV32I load/store funct3 encodings, access-size decode and the
//   alignment rule used by the lane logic.
//   No ports (package).
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // RV32I load funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32I store funct3
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_NONE = 2'd3
  } acc_size_t;

  // SZ_NONE marks a funct3 that is illegal for the given direction.
  function automatic acc_size_t decode_size(input logic we, input logic [2:0] funct3);
    acc_size_t sz;
    sz = SZ_NONE;
    if (we) begin
      case (funct3)
        F3_SB:   sz = SZ_BYTE;
        F3_SH:   sz = SZ_HALF;
        F3_SW:   sz = SZ_WORD;
        default: sz = SZ_NONE;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: sz = SZ_BYTE;
        F3_LH, F3_LHU: sz = SZ_HALF;
        F3_LW:         sz = SZ_WORD;
        default:       sz = SZ_NONE;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input acc_size_t sz, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (sz)
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Request/response bus between a load/store initiator and the data-memory
//   responder.
//   Request : req_valid/req_ready handshake, req_we, req_addr (byte address),
//             req_wdata (byte/half in low bits), req_funct3 (RV32I size/sign).
//   Response: rsp_valid/rsp_ready handshake, rsp_rdata (extended load data),
//             rsp_err (misaligned, out of range or illegal funct3).
//   Modports: master = initiator, slave = responder.
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_responder_align.sv
// dmem_align
//   Combinational lane logic for one memory access: error detection,
//   store byte enables and lane steering, load extraction and extension.
//   Ports:
//     we, addr, wdata, funct3 : the access being performed
//     mem_word                : the addressed 32-bit word read from the array
//     byte_en                 : bytes to write (all zero on error)
//     store_data              : wdata replicated into every lane
//     load_data               : right-aligned, extended load result
//                               (zero for stores and errors)
//     err                     : illegal funct3, misaligned or out of range
module dmem_align
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [31:0] mem_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        err
);

  acc_size_t   size;
  logic        bad_f3;
  logic        misaligned;
  logic        out_of_range;
  logic [31:0] shifted;

  always_comb begin
    size         = decode_size(we, funct3);
    bad_f3       = (size == SZ_NONE);
    misaligned   = is_misaligned(size, addr[1:0]);
    out_of_range = ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
    err          = bad_f3 || misaligned || out_of_range;
  end

  // Replicating the low bits into every lane lets byte_en alone pick
  // where the data lands.
  always_comb begin
    byte_en    = 4'b0000;
    store_data = wdata;
    case (size)
      SZ_BYTE: begin
        byte_en    = 4'b0001 << addr[1:0];
        store_data = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        byte_en    = addr[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        byte_en    = 4'b1111;
        store_data = wdata;
      end
      default: begin
        byte_en    = 4'b0000;
        store_data = wdata;
      end
    endcase
    if (err) begin
      byte_en = 4'b0000;
    end
  end

  // funct3[2] distinguishes LBU/LHU (zero extend) from LB/LH (sign extend).
  always_comb begin
    shifted   = mem_word >> {addr[1:0], 3'b000};
    load_data = 32'h0;
    case (size)
      SZ_BYTE: load_data = funct3[2] ? {24'h0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = funct3[2] ? {16'h0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      SZ_WORD: load_data = mem_word;
      default: load_data = 32'h0;
    endcase
    if (err || we) begin
      load_data = 32'h0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder with a fixed number of wait states. Accepts one
//   load/store at a time, performs it on the edge that enters RESP and holds
//   the response until the initiator takes it.
//   Parameters:
//     DEPTH_WORDS : number of 32-bit words in the backing store
//     WAIT_CYCLES : extra wait states between accept and response (0..15)
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset (array contents are kept)
//     bus   : dmem_responder_if slave modport (request and response)
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  dmem_responder_if.slave    bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [2:0]  cap_funct3;

  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [2:0]  acc_funct3;
  logic [IDX_W-1:0] acc_idx;
  logic [31:0] mem_word;
  logic [3:0]  byte_en;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        acc_err;

  logic        accept;
  logic        access_en;

  logic [31:0] mem [DEPTH_WORDS];

  assign accept = (state == ST_IDLE) && bus.req_valid && req_ready_q;

  // With zero wait states the access happens on the accept edge itself,
  // before the capture registers are loaded, so IDLE uses the live bus.
  always_comb begin
    acc_we     = cap_we;
    acc_addr   = cap_addr;
    acc_wdata  = cap_wdata;
    acc_funct3 = cap_funct3;
    if (state == ST_IDLE) begin
      acc_we     = bus.req_we;
      acc_addr   = bus.req_addr;
      acc_wdata  = bus.req_wdata;
      acc_funct3 = bus.req_funct3;
    end
  end

  assign access_en = (WAIT_CYCLES == 0) ? accept
                                        : ((state == ST_WAIT) && (wait_cnt == 4'd0));
  assign acc_idx   = acc_addr[IDX_W+1:2];
  assign mem_word  = mem[acc_idx];

  dmem_align #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_align (
    .we         (acc_we),
    .addr       (acc_addr),
    .wdata      (acc_wdata),
    .funct3     (acc_funct3),
    .mem_word   (mem_word),
    .byte_en    (byte_en),
    .store_data (store_data),
    .load_data  (load_data),
    .err        (acc_err)
  );

  // The wait counter is loaded with WAIT_CYCLES-1 so that RESP is entered
  // after exactly WAIT_CYCLES edges spent in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wait_cnt    <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      cap_we      <= 1'b0;
      cap_addr    <= 32'h0;
      cap_wdata   <= 32'h0;
      cap_funct3  <= 3'b000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cap_we      <= bus.req_we;
            cap_addr    <= bus.req_addr;
            cap_wdata   <= bus.req_wdata;
            cap_funct3  <= bus.req_funct3;
            req_ready_q <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state       <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= load_data;
              rsp_err_q   <= acc_err;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_data;
            rsp_err_q   <= acc_err;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state       <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Array is deliberately not reset. Reset forces IDLE asynchronously, so
  // access_en drops and an abandoned store never commits.
  always_ff @(posedge clk) begin
    if (access_en && acc_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[acc_idx][8*i +: 8] <= store_data[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
